aes_key_expand_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_rot_word.sv | 17 +
 rtl/aes_sub_word.sv | 42 ++++
 rtl/aes_key_expand_seq.sv | 143 ++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and helpers for the iterative AES-128 key schedule.
//   word_t  : one 32-bit key-schedule word, byte 0 in bits [31:24]
//   byte_t  : one 8-bit GF(2^8) element
//   state_e : key-expansion FSM states
//   xtime   : multiply-by-x in GF(2^8), used to step the round constant
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam byte_t       RCON_INIT = 8'h01;
    localparam byte_t       RCON_POLY = 8'h1B;
    localparam int unsigned NR        = 10;

    // Multiply by x modulo the AES polynomial: shift, then fold the carry back in.
    function automatic byte_t xtime(input byte_t r);
        byte_t res;
        if (r[7]) begin
            res = {r[6:0], 1'b0} ^ RCON_POLY;
        end else begin
            res = {r[6:0], 1'b0};
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_rot_word.sv
// -----------------------------------------------------------------------------
// aes_rot_word
// RotWord stage: cyclic one-byte left rotation of a key-schedule word,
// [b0,b1,b2,b3] -> [b1,b2,b3,b0].
//   word_in  : input word, b0 in [31:24]
//   word_out : rotated word
// -----------------------------------------------------------------------------
module aes_rot_word
    import aes_pkg::*;
(
    input  word_t word_in,
    output word_t word_out
);

    assign word_out = {word_in[23:0], word_in[31:24]};

endmodule

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// SubWord stage: applies the AES S-box independently to each byte of a word.
// Purely combinational; four parallel table lookups.
//   word_in  : input word
//   word_out : substituted word, same byte order
// -----------------------------------------------------------------------------
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t word_in,
    output word_t word_out
);

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte-wise S-box substitution.
    always_comb begin
        word_out = 32'h0;
        for (int i = 0; i < 4; i++) begin
            word_out[8*i +: 8] = SBOX[word_in[8*i +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// -----------------------------------------------------------------------------
// aes_key_expand_seq
// Iterative AES-128 key-schedule engine. A cipher key accepted on start is
// streamed out as round keys 0..NR over a valid/ready interface, one key per
// handshake. Only the current round key is stored; the next one is derived
// combinationally from it (RotWord -> SubWord -> Rcon -> word-chain XOR).
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin expansion; only looked at while idle
//   key_in     : cipher key, w0 in [127:96], sampled with an accepted start
//   busy       : expansion in progress until the last key transfers
//   rk_valid   : rk_out/rk_idx carry a valid round key
//   rk_ready   : consumer accepts the presented key
//   rk_out     : round key, same word/byte order as key_in
//   rk_idx     : round index of rk_out (0..NR)
//   done       : one-cycle pulse after the last key transfers
// -----------------------------------------------------------------------------
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_e       state_q, state_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    byte_t        rcon_q, rcon_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         transfer_s;
    word_t        rot_s, sub_s, t_s;
    logic [127:0] next_key_s;

    assign transfer_s = rk_valid_q & rk_ready;

    aes_rot_word u_rot_word (
        .word_in  (rk_out_q[31:0]),
        .word_out (rot_s)
    );

    aes_sub_word u_sub_word (
        .word_in  (rot_s),
        .word_out (sub_s)
    );

    // Next round key: mix the transformed last word into w0, then chain.
    always_comb begin
        t_s                = sub_s ^ {rcon_q, 24'h000000};
        next_key_s         = 128'h0;
        next_key_s[127:96] = rk_out_q[127:96] ^ t_s;
        next_key_s[95:64]  = rk_out_q[95:64]  ^ next_key_s[127:96];
        next_key_s[63:32]  = rk_out_q[63:32]  ^ next_key_s[95:64];
        next_key_s[31:0]   = rk_out_q[31:0]   ^ next_key_s[63:32];
    end

    // FSM next-state and output-register next values; everything holds by default.
    always_comb begin
        state_d    = state_q;
        rk_out_d   = rk_out_q;
        rk_idx_d   = rk_idx_q;
        rcon_d     = rcon_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rk_out_d   = key_in;
                    rk_idx_d   = 4'd0;
                    rcon_d     = RCON_INIT;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (transfer_s) begin
                    if (rk_idx_q == LAST_IDX) begin
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rk_out_d = next_key_s;
                        rk_idx_d = rk_idx_q + 4'd1;
                        rcon_d   = xtime(rcon_q);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d    = IDLE;
                rk_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rk_out_q   <= 128'h0;
            rk_idx_q   <= 4'd0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_out_q   <= rk_out_d;
            rk_idx_q   <= rk_idx_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
    assign rk_idx   = rk_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;

    always #5 clk = ~clk;

    aes_key_expand_seq #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfer_count = 0;
    int   ready_limit = 0;
    bit   rand_ready = 1'b0;
    bit   done_exp = 1'b0;
    bit   held = 1'b0;
    logic [127:0] held_out;
    logic [3:0]   held_idx;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    // FIPS-197 expansion of KEY_A
    logic [127:0] exp_a [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // expansion of the all-zero key
    logic [127:0] exp_z [0:10] = '{
        128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input bit zero_key, input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({4'(i), zero_key ? exp_z[i] : exp_a[i]});
        end
    endtask

    task automatic issue_start(input logic [127:0] k);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = 128'h0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d keys outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // ready driver: allows ready_limit transfers, optionally random
    initial begin
        rk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (xfer_count < ready_limit) begin
                rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                rk_ready = 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard on every transfer, checks done and hold stability
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held     = 1'b0;
                done_exp = 1'b0;
            end else begin
                check("done", {127'h0, done}, {127'h0, done_exp});
                done_exp = 1'b0;
                if (held && rk_valid) begin
                    check("hold_out", rk_out, held_out);
                    check("hold_idx", {124'h0, rk_idx}, {124'h0, held_idx});
                end
                held = 1'b0;
                if (rk_valid && rk_ready) begin
                    xfer_count++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got idx %0d, expected no transfer", rk_idx);
                    end else begin
                        e = sb_q.pop_front();
                        check("rk_idx", {124'h0, rk_idx}, {124'h0, e.idx});
                        check("rk_out", rk_out, e.key);
                        if (e.idx == 4'd10) done_exp = 1'b1;
                    end
                end else if (rk_valid) begin
                    held     = 1'b1;
                    held_out = rk_out;
                    held_idx = rk_idx;
                end
            end
        end
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = 128'h0;
        #12;
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_valid", {127'h0, rk_valid}, 128'h0);
        check("rst_out", rk_out, 128'h0);
        check("rst_idx", {124'h0, rk_idx}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // key A, ready always high, stray start at idx 4
        xfer_count  = 0;
        ready_limit = 11;
        rand_ready  = 1'b0;
        push_seq(1'b0, 11);
        issue_start(KEY_A);
        check("busy_started", {127'h0, busy}, 128'h1);
        n = 0;
        while (rk_idx != 4'd4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_idx4", {124'h0, rk_idx}, 128'h4);
        start  = 1'b1;
        key_in = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = 128'h0;
        wait_drain(60);
        #1;
        check("busy_end", {127'h0, busy}, 128'h0);
        check("valid_end", {127'h0, rk_valid}, 128'h0);
        repeat (3) @(posedge clk);

        // key A, random ready
        xfer_count = 0;
        rand_ready = 1'b1;
        push_seq(1'b0, 11);
        issue_start(KEY_A);
        wait_drain(400);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        // all-zero key
        xfer_count = 0;
        push_seq(1'b1, 11);
        issue_start(128'h0);
        wait_drain(60);
        repeat (3) @(posedge clk);

        // reset while idx 6 is presented
        xfer_count  = 0;
        ready_limit = 6;
        push_seq(1'b0, 6);
        issue_start(KEY_A);
        n = 0;
        while (!(rk_valid && rk_idx == 4'd6) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_idx6", {124'h0, rk_idx}, 128'h6);
        check("sb_empty_idx6", 128'(sb_q.size()), 128'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {127'h0, busy}, 128'h0);
        check("arst_valid", {127'h0, rk_valid}, 128'h0);
        check("arst_done", {127'h0, done}, 128'h0);
        check("arst_idx", {124'h0, rk_idx}, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // restart after reset, then new start in the done cycle
        xfer_count  = 0;
        ready_limit = 11;
        push_seq(1'b0, 11);
        issue_start(KEY_A);
        wait_drain(60);
        #1;
        check("done_cycle", {127'h0, done}, 128'h1);
        xfer_count  = 0;
        ready_limit = 1;
        start       = 1'b1;
        key_in      = {128{1'b1}};
        sb_q.push_back({4'd0, {128{1'b1}}});
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = 128'h0;
        check("ff_valid", {127'h0, rk_valid}, 128'h1);
        check("ff_idx", {124'h0, rk_idx}, 128'h0);
        check("ff_out", rk_out, {128{1'b1}});
        wait_drain(20);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
